// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module  : operand_fetch
// Purpose : Register-read stage. It holds the 16x16 register file and a tag
//           line of in-flight writes. It stalls decode on RAW hazards and
//           registers pc/ins/operands for the ALU.
// Option  : FR_WB_BYPASS_EN forwards same-cycle writeback data to the read
//           and drops the writeback tag from the hazard check.
// Rev     : 1.0  initial release
// ============================================================================
module operand_fetch #(
  parameter int PIPE_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_valid,
  input  logic [15:0] d_pc,
  input  logic [15:0] d_ins,
  output logic        d_ready,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_reg,
  input  logic [15:0] wb_data,
  output logic        fr_valid,
  output logic [15:0] fr_pc,
  output logic [15:0] fr_ins,
  output logic [15:0] fr_operand_1,
  output logic [15:0] fr_operand_2
);

  localparam logic [15:0] BUBBLE = 16'hF000;
`ifdef FR_WB_BYPASS_EN
  localparam int CHECKED = PIPE_DEPTH - 1;
`else
  localparam int CHECKED = PIPE_DEPTH;
`endif

  logic [15:0] regs [16];
  logic [PIPE_DEPTH-1:0] tag_v;
  logic [3:0]  tag_r [PIPE_DEPTH];

  logic [3:0]  op, ra, rb, rt;
  logic        use_a, use_b, use_t, writes_rt;
  logic        hazard, issue;
  logic [15:0] read_a, read_b, read_t;

  assign op = d_ins[15:12];
  assign ra = d_ins[11:8];
  assign rb = d_ins[7:4];
  assign rt = d_ins[3:0];

  always_comb begin
    use_a     = (op != 4'd4) && (op != 4'd15);
    use_t     = (op == 4'd5) || (op == 4'd6);
    use_b     = use_a && !use_t;
    writes_rt = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd14};
  end

  // R0 is never a hazard source; it always reads as zero.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < CHECKED; i++) begin
      if (tag_v[i]) begin
        if (use_a && (ra != 4'd0) && (tag_r[i] == ra)) hazard = 1'b1;
        if (use_b && (rb != 4'd0) && (tag_r[i] == rb)) hazard = 1'b1;
        if (use_t && (rt != 4'd0) && (tag_r[i] == rt)) hazard = 1'b1;
      end
    end
  end

  assign d_ready = !hazard && !flush && !rst;
  assign issue   = d_valid && d_ready;

  always_comb begin
    read_a = (ra == 4'd0) ? 16'h0000 : regs[ra];
    read_b = (rb == 4'd0) ? 16'h0000 : regs[rb];
    read_t = (rt == 4'd0) ? 16'h0000 : regs[rt];
`ifdef FR_WB_BYPASS_EN
    if (wb_en && (wb_reg != 4'd0)) begin
      if (wb_reg == ra) read_a = wb_data;
      if (wb_reg == rb) read_b = wb_data;
      if (wb_reg == rt) read_t = wb_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
    end else if (wb_en && (wb_reg != 4'd0)) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // On flush the instruction just leaving FR is younger than the jump, so its tag dies.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) tag_r[i] <= 4'd0;
    end else begin
      tag_v[0] <= issue && writes_rt && (rt != 4'd0);
      tag_r[0] <= rt;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_r[i] <= tag_r[i-1];
      end
      if (flush) tag_v[1] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !issue) begin
      fr_valid     <= 1'b0;
      fr_pc        <= 16'h0000;
      fr_ins       <= BUBBLE;
      fr_operand_1 <= 16'h0000;
      fr_operand_2 <= 16'h0000;
    end else begin
      fr_valid     <= 1'b1;
      fr_pc        <= d_pc;
      fr_ins       <= d_ins;
      fr_operand_1 <= read_a;
      fr_operand_2 <= use_t ? read_t : read_b;
    end
  end

endmodule
`default_nettype wire
